// File: rtl/pd_onchip_mem_arbiter_if.sv
// Bus bundle between the two Avalon-MM masters, the arbiter
// and the single-port on-chip RAM.
interface pd_onchip_mem_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] a_address;
    logic              a_read;
    logic              a_write;
    logic [BE_W-1:0]   a_byteenable;
    logic [DATA_W-1:0] a_writedata;
    logic              a_waitrequest;
    logic [DATA_W-1:0] a_readdata;
    logic              a_readdatavalid;

    logic [ADDR_W-1:0] b_address;
    logic              b_read;
    logic              b_write;
    logic [BE_W-1:0]   b_byteenable;
    logic [DATA_W-1:0] b_writedata;
    logic              b_waitrequest;
    logic [DATA_W-1:0] b_readdata;
    logic              b_readdatavalid;

    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_chipselect;
    logic              mem_write;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    modport slave (
        input  a_address, a_read, a_write,
        input  a_byteenable, a_writedata,
        output a_waitrequest, a_readdata,
        output a_readdatavalid,
        input  b_address, b_read, b_write,
        input  b_byteenable, b_writedata,
        output b_waitrequest, b_readdata,
        output b_readdatavalid,
        output mem_address, mem_byteenable,
        output mem_writedata, mem_chipselect,
        output mem_write, mem_clken,
        input  mem_readdata
    );

    modport master (
        output a_address, a_read, a_write,
        output a_byteenable, a_writedata,
        input  a_waitrequest, a_readdata,
        input  a_readdatavalid,
        output b_address, b_read, b_write,
        output b_byteenable, b_writedata,
        input  b_waitrequest, b_readdata,
        input  b_readdatavalid,
        input  mem_address, mem_byteenable,
        input  mem_writedata, mem_chipselect,
        input  mem_write, mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/pd_onchip_mem_arbiter.sv
// Round-robin two-port arbiter for the single-port on-chip RAM,
// with in-order read return, OOR flagging and quiesce/freeze.
module pd_onchip_mem_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int MEM_WORDS    = 10024,
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset_n,
    pd_onchip_mem_arbiter_if.slave bus,
    input  logic quiesce_req,
    output logic quiesce_ack,
    output logic err_oor,
    input  logic err_clr
);
    localparam int BE_W = DATA_W / 8;
    localparam int L    = READ_LATENCY;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(MEM_WORDS);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        FROZEN = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic grant_en;
    logic pri;
    logic req_a;
    logic req_b;
    logic gnt_a;
    logic gnt_b;
    logic gnt;
    logic sel_write;
    logic sel_oor;
    logic drained;

    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wd;

    logic [L-1:0] pipe_v;
    logic [L-1:0] pipe_b;
    logic [L-1:0] pipe_oor;

    // Combinational round-robin grant and request mux.
    always_comb begin
        req_a     = bus.a_read | bus.a_write;
        req_b     = bus.b_read | bus.b_write;
        gnt_a     = grant_en & req_a & (~req_b | ~pri);
        gnt_b     = grant_en & req_b & (~req_a | pri);
        gnt       = gnt_a | gnt_b;
        sel_addr  = '0;
        sel_be    = '0;
        sel_wd    = '0;
        sel_write = 1'b0;
        unique case (1'b1)
            gnt_a: begin
                sel_addr  = bus.a_address;
                sel_be    = bus.a_byteenable;
                sel_wd    = bus.a_writedata;
                sel_write = bus.a_write;
            end
            gnt_b: begin
                sel_addr  = bus.b_address;
                sel_be    = bus.b_byteenable;
                sel_wd    = bus.b_writedata;
                sel_write = bus.b_write;
            end
            default: ;
        endcase
        sel_oor = ({1'b0, sel_addr} >= LIMIT);
    end

    assign bus.a_waitrequest  = req_a & ~gnt_a;
    assign bus.b_waitrequest  = req_b & ~gnt_b;
    assign bus.mem_address    = sel_addr;
    assign bus.mem_byteenable = sel_be;
    assign bus.mem_writedata  = sel_wd;
    assign bus.mem_chipselect = gnt & ~sel_oor;
    assign bus.mem_write      = gnt & ~sel_oor & sel_write;

    assign drained = ~|pipe_v
                   & ~bus.a_readdatavalid
                   & ~bus.b_readdatavalid;

    // Priority flips to the other port after every grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pri <= 1'b0;
        end else if (gnt) begin
            pri <= gnt_a;
        end
    end

    // Sticky OOR flag; a new OOR accept beats a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_oor <= 1'b0;
        end else if (gnt & sel_oor) begin
            err_oor <= 1'b1;
        end else if (err_clr) begin
            err_oor <= 1'b0;
        end
    end

    // Return tag pipeline aligned with the RAM read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_v   <= '0;
            pipe_b   <= '0;
            pipe_oor <= '0;
        end else begin
            pipe_v[0]   <= gnt & ~sel_write;
            pipe_b[0]   <= gnt_b;
            pipe_oor[0] <= sel_oor;
            for (int i = 1; i < L; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_b[i]   <= pipe_b[i-1];
                pipe_oor[i] <= pipe_oor[i-1];
            end
        end
    end

    // Steer returned data into the tagged port's output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.a_readdata      <= '0;
            bus.b_readdata      <= '0;
            bus.a_readdatavalid <= 1'b0;
            bus.b_readdatavalid <= 1'b0;
        end else begin
            bus.a_readdatavalid <= pipe_v[L-1] & ~pipe_b[L-1];
            bus.b_readdatavalid <= pipe_v[L-1] & pipe_b[L-1];
            if (pipe_v[L-1] & ~pipe_b[L-1]) begin
                bus.a_readdata <= pipe_oor[L-1] ? '0
                                                : bus.mem_readdata;
            end
            if (pipe_v[L-1] & pipe_b[L-1]) begin
                bus.b_readdata <= pipe_oor[L-1] ? '0
                                                : bus.mem_readdata;
            end
        end
    end

    // Quiesce FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Quiesce FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (quiesce_req) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!quiesce_req)  state_nxt = RUN;
                else if (drained)  state_nxt = FROZEN;
            end
            FROZEN: begin
                if (!quiesce_req) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // Quiesce FSM outputs.
    always_comb begin
        grant_en      = (state == RUN);
        quiesce_ack   = (state == FROZEN);
        bus.mem_clken = (state != FROZEN);
    end
endmodule

// File: tb/tb_pd_onchip_mem_arbiter.sv
// Self-checking bench for pd_onchip_mem_arbiter: directed steps
// plus random traffic against a transaction-level model.
module tb_pd_onchip_mem_arbiter;
    localparam int MEM_WORDS = 10024;
    localparam int RL        = 1;

    logic clk = 1'b0;
    logic reset_n;
    logic quiesce_req;
    logic quiesce_ack;
    logic err_oor;
    logic err_clr;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int cnt_a  = 0;
    int cnt_b  = 0;

    pd_onchip_mem_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus ();

    pd_onchip_mem_arbiter #(
        .ADDR_W(14), .DATA_W(32),
        .MEM_WORDS(MEM_WORDS), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .quiesce_req(quiesce_req), .quiesce_ack(quiesce_ack),
        .err_oor(err_oor), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:MEM_WORDS-1];

    always @(posedge clk) begin
        if (bus.mem_clken && bus.mem_chipselect) begin
            if (bus.mem_write) begin
                for (int i = 0; i < 4; i++)
                    if (bus.mem_byteenable[i])
                        ram[bus.mem_address][8*i +: 8] <=
                            bus.mem_writedata[8*i +: 8];
            end else begin
                bus.mem_readdata <= ram[bus.mem_address];
            end
        end
    end

    typedef struct {
        int          due;
        bit          port;
        logic [31:0] data;
    } rd_t;

    rd_t         q[$];
    logic [31:0] ref_mem [int];
    bit          mpri;
    bit          merr;
    int          mst;

    function automatic logic [31:0] mem_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mpri = 1'b0;
        merr = 1'b0;
        mst  = 0;
    endtask

    task automatic cycle();
        bit ra, rb, ga, gb, wr, oor, va, vb, en;
        int addr;
        logic [3:0]  be;
        logic [31:0] wd, dv, nw;
        rd_t e;
        @(negedge clk);
        ra = bus.a_read | bus.a_write;
        rb = bus.b_read | bus.b_write;
        en = (mst == 0);
        ga = en && ra && (!rb || !mpri);
        gb = en && rb && (!ra || mpri);
        addr = 0; wr = 0; be = 0; wd = 0;
        if (ga) begin
            addr = int'(bus.a_address); wr = bus.a_write;
            be = bus.a_byteenable; wd = bus.a_writedata;
        end else if (gb) begin
            addr = int'(bus.b_address); wr = bus.b_write;
            be = bus.b_byteenable; wd = bus.b_writedata;
        end
        oor = (ga || gb) && addr >= MEM_WORDS;
        va = 0; vb = 0; dv = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            dv = e.data;
            if (e.port) vb = 1; else va = 1;
        end
        chk("a_wait", bus.a_waitrequest, ra && !ga);
        chk("b_wait", bus.b_waitrequest, rb && !gb);
        chk("a_rdv", bus.a_readdatavalid, va);
        chk("b_rdv", bus.b_readdatavalid, vb);
        if (va) chk("a_rdata", bus.a_readdata, dv);
        if (vb) chk("b_rdata", bus.b_readdata, dv);
        chk("mem_cs", bus.mem_chipselect, (ga || gb) && !oor);
        chk("mem_we", bus.mem_write, (ga || gb) && !oor && wr);
        chk("err_oor", err_oor, merr);
        chk("q_ack", quiesce_ack, mst == 2);
        chk("clken", bus.mem_clken, mst != 2);
        cnt_a += int'(bus.a_readdatavalid);
        cnt_b += int'(bus.b_readdatavalid);
        @(posedge clk);
        if (ga || gb) begin
            mpri = ga;
            if (oor) merr = 1'b1;
            else if (err_clr) merr = 1'b0;
            if (wr) begin
                if (!oor) begin
                    nw = mem_rd(addr);
                    for (int i = 0; i < 4; i++)
                        if (be[i]) nw[8*i +: 8] = wd[8*i +: 8];
                    ref_mem[addr] = nw;
                end
            end else begin
                e.due  = cyc + 1 + RL;
                e.port = gb;
                e.data = oor ? 32'h0 : mem_rd(addr);
                q.push_back(e);
            end
        end else if (err_clr) begin
            merr = 1'b0;
        end
        case (mst)
            0: if (quiesce_req) mst = 1;
            1: if (!quiesce_req) mst = 0;
               else if (q.size() == 0 && !va && !vb) mst = 2;
            default: if (!quiesce_req) mst = 0;
        endcase
        cyc++;
        #1;
    endtask

    task automatic idle_bus();
        bus.a_read = 0; bus.a_write = 0;
        bus.b_read = 0; bus.b_write = 0;
        bus.a_address = 0; bus.b_address = 0;
        bus.a_byteenable = 0; bus.b_byteenable = 0;
        bus.a_writedata = 0; bus.b_writedata = 0;
    endtask

    task automatic idle(input int n);
        idle_bus();
        repeat (n) cycle();
    endtask

    task automatic a_acc(input bit w, input logic [13:0] ad,
                         input logic [3:0] be, input logic [31:0] d);
        idle_bus();
        bus.a_read = !w; bus.a_write = w; bus.a_address = ad;
        bus.a_byteenable = be; bus.a_writedata = d;
        cycle();
    endtask

    task automatic b_acc(input bit w, input logic [13:0] ad,
                         input logic [3:0] be, input logic [31:0] d);
        idle_bus();
        bus.b_read = !w; bus.b_write = w; bus.b_address = ad;
        bus.b_byteenable = be; bus.b_writedata = d;
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r;
        logic [13:0] bnd [3];
        bnd[0] = 14'd10023; bnd[1] = 14'd10024; bnd[2] = 14'd16383;
        for (int i = 0; i < MEM_WORDS; i++) ram[i] = 32'h0;
        bus.mem_readdata = 32'h0;
        idle_bus();
        quiesce_req = 0; err_clr = 0;
        reset_n = 0;
        model_reset();
        #12;
        chk("rst_a_wait", bus.a_waitrequest, 0);
        chk("rst_b_wait", bus.b_waitrequest, 0);
        chk("rst_a_rdv", bus.a_readdatavalid, 0);
        chk("rst_b_rdv", bus.b_readdatavalid, 0);
        chk("rst_a_rd", bus.a_readdata, 0);
        chk("rst_b_rd", bus.b_readdata, 0);
        chk("rst_maddr", bus.mem_address, 0);
        chk("rst_mbe", bus.mem_byteenable, 0);
        chk("rst_mwd", bus.mem_writedata, 0);
        chk("rst_mcs", bus.mem_chipselect, 0);
        chk("rst_mwe", bus.mem_write, 0);
        chk("rst_clken", bus.mem_clken, 1);
        chk("rst_ack", quiesce_ack, 0);
        chk("rst_err", err_oor, 0);
        @(posedge clk); #1;
        reset_n = 1;
        idle(3);

        a_acc(1, 14'h0010, 4'hF, 32'h12345678);
        a_acc(0, 14'h0010, 4'hF, 32'h0);
        idle(3);
        chk("wr_rd_a", bus.a_readdata, 32'h12345678);

        a_acc(1, 14'h0020, 4'hF, 32'hFFFFFFFF);
        a_acc(1, 14'h0020, 4'h2, 32'hAABBCCDD);
        a_acc(0, 14'h0020, 4'hF, 32'h0);
        idle(3);
        chk("be_merge", bus.a_readdata, 32'hFFFFCCFF);

        cnt_a = 0; cnt_b = 0;
        idle_bus();
        bus.a_read = 1; bus.a_address = 14'h0010;
        bus.b_read = 1; bus.b_address = 14'h0020;
        repeat (8) cycle();
        idle(4);
        chk("beats_a", cnt_a, 4);
        chk("beats_b", cnt_b, 4);
        chk("last_b", bus.b_readdata, 32'hFFFFCCFF);

        b_acc(0, 14'd10024, 4'hF, 32'h0);
        idle(3);
        chk("oor_rd", bus.b_readdata, 32'h0);
        chk("oor_err", err_oor, 1);
        b_acc(1, 14'd10024, 4'hF, 32'hDEADBEEF);
        idle(2);
        err_clr = 1; cycle(); err_clr = 0;
        idle(1);
        chk("err_clr", err_oor, 0);
        err_clr = 1;
        b_acc(0, 14'd16383, 4'hF, 32'h0);
        err_clr = 0;
        idle(2);
        chk("err_set_wins", err_oor, 1);
        err_clr = 1; cycle(); err_clr = 0;
        a_acc(0, 14'd10023, 4'hF, 32'h0);
        idle(3);

        for (int k = 0; k < 200; k++) begin
            r = int'($urandom_range(0, 7));
            bus.a_read  = $urandom_range(0, 1) == 1;
            bus.a_write = $urandom_range(0, 2) == 0;
            bus.b_read  = $urandom_range(0, 1) == 1;
            bus.b_write = $urandom_range(0, 2) == 0;
            bus.a_address = (r == 0) ? bnd[$urandom_range(0, 2)]
                                     : 14'($urandom_range(0, 31));
            bus.b_address = (r == 1) ? bnd[$urandom_range(0, 2)]
                                     : 14'($urandom_range(0, 31));
            bus.a_byteenable = 4'($urandom);
            bus.b_byteenable = 4'($urandom);
            bus.a_writedata  = $urandom;
            bus.b_writedata  = $urandom;
            err_clr = $urandom_range(0, 9) == 0;
            cycle();
        end
        err_clr = 0;
        idle(4);

        a_acc(0, 14'h0010, 4'hF, 32'h0);
        quiesce_req = 1;
        cycle();
        repeat (6) cycle();
        chk("frz_ack", quiesce_ack, 1);
        chk("frz_clken", bus.mem_clken, 0);
        chk("frz_stall", bus.a_waitrequest, 1);
        quiesce_req = 0;
        cycle();
        chk("run_grant", bus.a_waitrequest, 0);
        cycle();
        idle(4);

        a_acc(0, 14'h0010, 4'hF, 32'h0);
        reset_n = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1;
        chk("rst_mid_rd", bus.a_readdata, 0);
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
